// File: rtl/s1_pkg.sv
// Shared decode control-word field positions and scoreboard FSM state type.
package s1_pkg;

   localparam int unsigned AluBsel    = 0;
   localparam int unsigned Brh        = 4;
   localparam int unsigned MemWe      = 7;
   localparam int unsigned RegWe      = 9;
   localparam int unsigned RegInselHi = 11;
   localparam int unsigned RegInselLo = 10;

   typedef enum logic {
      StRun,
      StDrain
   } sb_state_e;

   function automatic logic [1:0] reg_insel(input logic [11:0] cw);
      return cw[RegInselHi:RegInselLo];
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset, synchronous clear and count enable.
module sat_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   output logic [Width-1:0] count
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != '1)) begin
         count_d = count_q + Width'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW/WAW interlock: tracks in-flight register writes and drains them before fences.
module hazard_scoreboard
   import s1_pkg::*;
#(
   parameter int unsigned NREGS         = 32,
   parameter int unsigned STALL_CNT_W   = 16,
   parameter int unsigned DRAIN_TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clk_en,
   input  logic                     id_valid,
   input  logic [11:0]              id_control_word,
   input  logic [$clog2(NREGS)-1:0] id_rs1,
   input  logic [$clog2(NREGS)-1:0] id_rs2,
   input  logic [$clog2(NREGS)-1:0] id_rd,
   input  logic                     id_fence,
   input  logic                     wb_clr,
   input  logic [$clog2(NREGS)-1:0] wb_rd,
   output logic                     id_stall,
   output logic                     issue,
   output logic                     busy,
   output logic [NREGS-1:0]         pending,
   output logic [STALL_CNT_W-1:0]   stall_cycles,
   output logic                     sb_error
);

   localparam int unsigned DrainW = $clog2(DRAIN_TIMEOUT + 1);

   logic [NREGS-1:0]  pending_q, pending_d;
   sb_state_e         state_q, state_d;
   logic              sb_error_q;
   logic [DrainW-1:0] drain_cnt;
   logic              use_rs1, use_rs2, reg_we, hazard;
   logic              stall_en, drain_en, drain_clr;

   always_comb begin
      reg_we  = id_control_word[RegWe];
      use_rs1 = |id_control_word;
      use_rs2 = ~id_control_word[AluBsel] | id_control_word[Brh] | id_control_word[MemWe];
      hazard  = (use_rs1 && (id_rs1 != '0) && pending_q[id_rs1]) ||
                (use_rs2 && (id_rs2 != '0) && pending_q[id_rs2]) ||
                (reg_we  && (id_rd  != '0) && pending_q[id_rd]);
      id_stall = id_valid & (hazard | (id_fence & busy) | (state_q == StDrain));
      issue    = id_valid & ~id_stall;
   end

   // Set is applied after clear so a same-register collision resolves to set.
   always_comb begin
      pending_d = pending_q;
      if (wb_clr) begin
         pending_d[wb_rd] = 1'b0;
      end
      if (issue && reg_we && (id_rd != '0)) begin
         pending_d[id_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:   if (id_valid && id_fence && busy) state_d = StDrain;
         StDrain: if (pending_d == '0) state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q  <= '0;
         state_q    <= StRun;
         sb_error_q <= 1'b0;
      end else if (clk_en) begin
         pending_q <= pending_d;
         state_q   <= state_d;
         // The counter reaches the timeout on this same edge.
         if ((state_q == StDrain) && (drain_cnt == DrainW'(DRAIN_TIMEOUT - 1))) begin
            sb_error_q <= 1'b1;
         end
      end
   end

   assign stall_en  = clk_en & id_stall;
   assign drain_en  = clk_en & (state_q == StDrain);
   assign drain_clr = clk_en & (state_q == StRun);

   sat_counter #(
      .Width(STALL_CNT_W)
   ) u_stall_cnt (
      .clk  (clk),
      .rst  (rst),
      .en   (stall_en),
      .clr  (1'b0),
      .count(stall_cycles)
   );

   sat_counter #(
      .Width(DrainW)
   ) u_drain_cnt (
      .clk  (clk),
      .rst  (rst),
      .en   (drain_en),
      .clr  (drain_clr),
      .count(drain_cnt)
   );

   assign busy     = |pending_q;
   assign pending  = pending_q;
   assign sb_error = sb_error_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic vs a reference model.
module tb_hazard_scoreboard;

   localparam int NREGS = 32;
   localparam int SCW   = 16;
   localparam int DTO   = 255;

   logic        clk = 1'b0;
   logic        rst, clk_en, id_valid, id_fence, wb_clr;
   logic [11:0] cw;
   logic [4:0]  rs1, rs2, rd, wb_rd;
   logic        id_stall, issue, busy, sb_error;
   logic [NREGS-1:0] pending;
   logic [SCW-1:0]   stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   bit m_pend [NREGS];
   bit m_drain;
   int m_dcnt;
   int m_stall;
   bit m_err;
   bit model_ok = 1'b0;

   always #5 clk = ~clk;

   hazard_scoreboard #(
      .NREGS(NREGS),
      .STALL_CNT_W(SCW),
      .DRAIN_TIMEOUT(DTO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .clk_en         (clk_en),
      .id_valid       (id_valid),
      .id_control_word(cw),
      .id_rs1         (rs1),
      .id_rs2         (rs2),
      .id_rd          (rd),
      .id_fence       (id_fence),
      .wb_clr         (wb_clr),
      .wb_rd          (wb_rd),
      .id_stall       (id_stall),
      .issue          (issue),
      .busy           (busy),
      .pending        (pending),
      .stall_cycles   (stall_cycles),
      .sb_error       (sb_error)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit m_busy();
      for (int i = 0; i < NREGS; i++) if (m_pend[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_vec();
      logic [31:0] v = '0;
      for (int i = 0; i < NREGS; i++) v[i] = m_pend[i];
      return v;
   endfunction

   function automatic bit m_stall_now();
      bit r1, r2, haz;
      r1  = (cw != 12'h000);
      r2  = !cw[0] || cw[4] || cw[7];
      haz = (r1 && rs1 != 0 && m_pend[rs1]) || (r2 && rs2 != 0 && m_pend[rs2]) ||
            (cw[9] && rd != 0 && m_pend[rd]);
      return id_valid && (haz || (id_fence && m_busy()) || m_drain);
   endfunction

   // Reference model advances on every clock edge from the pre-edge inputs.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
         m_drain  = 1'b0;
         m_dcnt   = 0;
         m_stall  = 0;
         m_err    = 1'b0;
         model_ok = 1'b1;
      end else if (clk_en) begin
         bit st, was_busy;
         st       = m_stall_now();
         was_busy = m_busy();
         if (st && m_stall < 65535) m_stall++;
         if (wb_clr) m_pend[wb_rd] = 1'b0;
         if (id_valid && !st && cw[9] && rd != 0) m_pend[rd] = 1'b1;
         if (!m_drain) begin
            if (id_valid && id_fence && was_busy) begin
               m_drain = 1'b1;
               m_dcnt  = 0;
            end
         end else begin
            m_dcnt++;
            if (m_dcnt == DTO) m_err = 1'b1;
            if (!m_busy()) m_drain = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         check("model_id_stall", id_stall, m_stall_now());
         check("model_issue", issue, id_valid && !m_stall_now());
         check("model_pending", pending, m_vec());
         check("model_busy", busy, m_busy());
         check("model_stall_cycles", stall_cycles, m_stall);
         check("model_sb_error", sb_error, m_err);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [11:0] c, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d, input logic f);
      id_valid = v;
      cw       = c;
      rs1      = a;
      rs2      = b;
      rd       = d;
      id_fence = f;
   endtask

   initial begin
      rst = 1'b1;
      clk_en = 1'b1;
      wb_clr = 1'b0;
      wb_rd  = '0;
      drive(1'b0, 12'h000, 0, 0, 0, 1'b0);
      step();
      step();
      rst = 1'b0;

      // Reset state
      drive(1'b1, 12'h000, 0, 0, 0, 1'b0);
      #1;
      check("rst_pending", pending, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_stall_cycles", stall_cycles, 0);
      check("rst_sb_error", sb_error, 1'b0);
      check("rst_id_stall", id_stall, 1'b0);
      check("rst_issue", issue, 1'b1);

      // Load-use RAW
      drive(1'b1, 12'h601, 2, 0, 5, 1'b0);
      #1;
      check("lu_load_issue", issue, 1'b1);
      step();
      for (int c = 1; c <= 4; c++) begin
         drive(1'b1, 12'h200, 5, 6, 8, 1'b0);
         wb_clr = (c == 4);
         wb_rd  = 5;
         #1;
         check("lu_stall", id_stall, 1'b1);
         step();
      end
      wb_clr = 1'b0;
      #1;
      check("lu_issue_c5", issue, 1'b1);
      check("lu_stall_cycles", stall_cycles, 4);
      step();
      check("lu_pending_rd8", pending, 32'h100);
      drive(1'b0, 12'h000, 0, 0, 0, 1'b0);
      wb_clr = 1'b1;
      wb_rd  = 8;
      step();
      wb_clr = 1'b0;

      // rs2 gating
      drive(1'b1, 12'h201, 0, 0, 7, 1'b0);
      step();
      check("g_pending7", pending, 32'h80);
      drive(1'b1, 12'h001, 0, 7, 0, 1'b0);
      #1;
      check("g_imm_no_stall", id_stall, 1'b0);
      cw = 12'h081;
      #1;
      check("g_store_stall", id_stall, 1'b1);
      drive(1'b0, 12'h000, 0, 0, 0, 1'b0);
      wb_clr = 1'b1;
      wb_rd  = 7;
      step();
      wb_clr = 1'b0;

      // Register 0 and WAW
      drive(1'b1, 12'h200, 0, 0, 0, 1'b0);
      step();
      check("w_r0_pending", pending, 32'h0);
      drive(1'b1, 12'h200, 0, 0, 3, 1'b0);
      step();
      check("w_pending3", pending, 32'h8);
      check("w_second_stall", id_stall, 1'b1);
      step();
      check("w_second_stall2", id_stall, 1'b1);
      wb_clr = 1'b1;
      wb_rd  = 3;
      #1;
      check("w_no_bypass", id_stall, 1'b1);
      step();
      wb_clr = 1'b0;
      #1;
      check("w_second_issue", issue, 1'b1);
      step();
      check("w_pending3_again", pending, 32'h8);
      drive(1'b0, 12'h000, 0, 0, 0, 1'b0);
      wb_clr = 1'b1;
      step();
      wb_clr = 1'b0;

      // Fence drain
      drive(1'b1, 12'h200, 0, 0, 3, 1'b0);
      step();
      rd = 9;
      step();
      check("f_pending", pending, 32'h208);
      drive(1'b1, 12'h000, 0, 0, 0, 1'b1);
      #1;
      check("f_fence_stall", id_stall, 1'b1);
      step();
      id_fence = 1'b0;
      #1;
      check("f_drain_holds", id_stall, 1'b1);
      id_fence = 1'b1;
      wb_clr   = 1'b1;
      wb_rd    = 3;
      step();
      wb_rd = 9;
      step();
      wb_clr = 1'b0;
      #1;
      check("f_fence_issue", issue, 1'b1);
      check("f_busy", busy, 1'b0);
      step();

      // Timeout and reset
      drive(1'b1, 12'h200, 0, 0, 2, 1'b0);
      step();
      drive(1'b1, 12'h000, 0, 0, 0, 1'b1);
      step();
      for (int i = 1; i <= DTO; i++) begin
         step();
         if (i == DTO - 1) check("t_no_err_early", sb_error, 1'b0);
      end
      check("t_sb_error", sb_error, 1'b1);
      check("t_still_stall", id_stall, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("t_rst_pending", pending, 32'h0);
      check("t_rst_busy", busy, 1'b0);
      check("t_rst_stall_cycles", stall_cycles, 0);
      check("t_rst_sb_error", sb_error, 1'b0);
      check("t_rst_id_stall", id_stall, 1'b0);
      check("t_rst_issue", issue, 1'b1);

      // clk_en freeze
      drive(1'b1, 12'h200, 0, 0, 4, 1'b0);
      step();
      check("c_pending4", pending, 32'h10);
      clk_en = 1'b0;
      drive(1'b1, 12'h200, 4, 0, 6, 1'b0);
      wb_clr = 1'b1;
      wb_rd  = 4;
      step();
      step();
      check("c_pending_frozen", pending, 32'h10);
      check("c_stall_frozen", stall_cycles, 0);
      wb_clr = 1'b0;
      drive(1'b1, 12'h200, 0, 0, 6, 1'b0);
      step();
      check("c_no_issue_set", pending, 32'h10);
      drive(1'b1, 12'h000, 0, 0, 0, 1'b1);
      step();
      step();
      id_fence = 1'b0;
      #1;
      check("c_fsm_frozen_run", id_stall, 1'b0);
      clk_en = 1'b1;
      drive(1'b0, 12'h000, 0, 0, 0, 1'b0);
      wb_clr = 1'b1;
      wb_rd  = 4;
      step();
      wb_clr = 1'b0;
      check("c_cleared", pending, 32'h0);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom_range(0, 199) == 0);
         clk_en   = ($urandom_range(0, 9) != 0);
         id_valid = ($urandom_range(0, 3) != 0);
         cw       = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
         if (!id_valid) cw = 12'h000;
         rs1      = 5'($urandom_range(0, 7));
         rs2      = 5'($urandom_range(0, 7));
         rd       = 5'($urandom_range(0, 7));
         id_fence = id_valid && ($urandom_range(0, 19) == 0);
         wb_clr   = ($urandom_range(0, 2) == 0);
         wb_rd    = 5'($urandom_range(0, 7));
         step();
      end
      rst = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
